regfile_access_arbiter: RTL and testbench
=========================================

// Module: regfile_access_arbiter
// PURPOSE
//  Shares the single-port 16-bit general-purpose register file between NUM_REQ requesters.
//  Typical requesters are operand fetch A, operand fetch B and writeback.
//  Grants one access per 2-cycle slot and drives the register controller's chip_enable/write_enable/address/valueIn.
//  Samples the register controller's valueOut and returns it to the read requester.
//  Sits between the decode/writeback stages and the register controller.
// PARAMETERS
//  DATA_WIDTH     16  register width
//  ADDR_WIDTH     4   register address width
//  NUM_REQ        3   number of requesters (2..8)
//  WRITE_PRIORITY 1   1: pending writes beat pending reads; 0: pure round-robin
//  STARVE_LIMIT   4   consecutive lost arbitrations after which a waiting read is forced (1..15)
// PORTS
//  clock          in   1                     single clock, all state on rising edge
//  reset          in   1                     synchronous, active-high
//  req_valid      in   NUM_REQ               per-requester request
//  req_write      in   NUM_REQ               1=write, 0=read
//  req_address    in   NUM_REQ*ADDR_WIDTH    requester i in bits [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_value      in   NUM_REQ*DATA_WIDTH    write data, same packing
//  req_ready      out  NUM_REQ               one-hot grant; handshake = valid & ready
//  resp_valid     out  NUM_REQ               one-hot, 1-cycle pulse carrying read data
//  resp_value     out  DATA_WIDTH            read data; valid only while resp_valid != 0
//  rf_chip_enable out  1                     to register controller
//  rf_write_enable out 1                     to register controller
//  rf_address     out  ADDR_WIDTH            to register controller
//  rf_valueIn     out  DATA_WIDTH            to register controller
//  rf_valueOut    in   DATA_WIDTH            from register controller
//  busy           out  1                     1 while state == ACCESS
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, rr_ptr=0, starve counters=0.
//   - All outputs 0.
//  Reset has priority over every event, including in ACCESS.
//  IDLE:
//   - If any req_valid is set, combinationally pick winner w and assert req_ready[w] for that cycle only.
//   - Next edge: state<=ACCESS. Register rf_chip_enable=1, rf_write_enable=req_write[w], rf_address and rf_valueIn from requester w.
//   - Register op/index w.
//   - If no req_valid is set, stay in IDLE with rf_chip_enable=0 and rf_write_enable=0.
//  ACCESS, exactly 1 cycle:
//   - rf_* held at the granted values. Unconditional next edge: state<=IDLE, rf_chip_enable<=0, rf_write_enable<=0.
//   - rf_address and rf_valueIn keep their last values.
//   - Read: resp_value<=rf_valueOut and resp_valid[w]<=1 at the same edge.
//   - Write: no response.
//   - req_ready is 0 in ACCESS. Throughput is 1 access per 2 cycles.
//  Latency, grant in cycle N:
//   - Register file accessed in N+1.
//   - Read data on resp_value with resp_valid in N+2.
//  Requester rules:
//   - Hold valid, write, address and value stable until ready.
//   - Requests may drop without a grant and are ignored.
//   - Request inputs may change after the handshake.
//  Arbitration order, evaluated in IDLE:
//   1. Any read whose starve counter >= STARVE_LIMIT wins. Ties are broken round-robin from rr_ptr.
//   2. If WRITE_PRIORITY=1, writes win, round-robin among writes from rr_ptr.
//   3. Otherwise, round-robin among all valid requests from rr_ptr.
//  After every grant: rr_ptr<=(w+1) mod NUM_REQ, wrapping NUM_REQ-1 -> 0.
//  Starve counter, per requester, 4 bits, saturating at 15:
//   - Increments on each grant to another requester while its own read is pending.
//   - Clears on its own grant, or when its req_valid=0.
//  Ordering:
//   - A write granted before a read to the same address is visible to that read.
//   - There is no forwarding and no reordering inside a slot.
//  Reset mid-ACCESS:
//   - Access is aborted and no resp_valid is issued.
//   - rf_chip_enable=0 from the next cycle.
//   - The write may already have reached the register file; requesters must reissue.
//  Simultaneous reset and req_valid: the request is ignored and req_ready stays 0.
// TESTING
//  T1: req2 writes reg3=16'h1234, then req0 reads reg3 (granted cycle N).
//      -> rf_chip_enable=1, rf_address=3 in N+1; resp_valid=3'b001, resp_value=16'h1234 in N+2.
//  T2: req0, req1 and req2 all read (addr 1,2,4) continuously from reset.
//      -> grant order 0,1,2,0 every 2 cycles; each resp_valid one-hot to the matching requester.
//  T3: WRITE_PRIORITY=1; same cycle, req0 reads reg5 and req1 writes reg5=16'hBEEF.
//      -> req1 granted first; the read returns 16'hBEEF.
//  T4: req1 writes back-to-back and req0 read held.
//      -> req0 granted no later than after 4 write grants (STARVE_LIMIT=4).
//  T5: reset asserted in the ACCESS cycle of a req1 read.
//      -> no resp_valid; all outputs 0 next cycle; the next contested grant goes to req0.
//  T6: req_valid pulsed for 1 cycle while another access is in ACCESS.
//      -> never granted; no rf_chip_enable activity for it.

Source files
------------

// File: rtl/regfile_access_arbiter.sv
// Arbitrates NUM_REQ requesters onto a single-port register file controller.
// One access per 2-cycle slot: grant in IDLE, drive the register file in ACCESS.

module regfile_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic grant,
    input  logic self_grant,
    input  logic req_valid,
    input  logic rd_pend,
    output logic starved
);
    logic [3:0] cnt;

    always_ff @(posedge clock) begin
        if (reset)
            cnt <= '0;
        else if (!req_valid)
            cnt <= '0;
        else if (grant) begin
            if (self_grant)
                cnt <= '0;
            else if (rd_pend && cnt != 4'hF)
                cnt <= cnt + 4'd1;
        end
    end

    assign starved = rd_pend && (cnt >= 4'(STARVE_LIMIT));
endmodule

module regfile_access_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int NUM_REQ        = 3,
    parameter int WRITE_PRIORITY = 1,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_value,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_value,
    output logic                          rf_chip_enable,
    output logic                          rf_write_enable,
    output logic [ADDR_WIDTH-1:0]         rf_address,
    output logic [DATA_WIDTH-1:0]         rf_valueIn,
    input  logic [DATA_WIDTH-1:0]         rf_valueOut,
    output logic                          busy
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_nxt;

    logic [IDX_W-1:0]   rr_ptr, win, idx, op_idx;
    logic [NUM_REQ-1:0] rd_pend, wr_pend, starved, cand;
    logic               grant, found, op_read;

    assign rd_pend = req_valid & ~req_write;
    assign wr_pend = req_valid &  req_write;
    // A request presented together with reset is never granted.
    assign grant   = (state == IDLE) && (|req_valid) && !reset;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_starve
        regfile_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_ctr (
            .clock      (clock),
            .reset      (reset),
            .grant      (grant),
            .self_grant (req_ready[i]),
            .req_valid  (req_valid[i]),
            .rd_pend    (rd_pend[i]),
            .starved    (starved[i])
        );
    end

    // Candidate set by priority class, then round-robin from rr_ptr within it.
    always_comb begin
        cand  = req_valid;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        if (|starved)
            cand = starved;
        else if (WRITE_PRIORITY != 0 && |wr_pend)
            cand = wr_pend;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && cand[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ACCESS;
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (grant)
            req_ready[win] = 1'b1;
        busy = (state == ACCESS);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr          <= '0;
            rf_chip_enable  <= 1'b0;
            rf_write_enable <= 1'b0;
            rf_address      <= '0;
            rf_valueIn      <= '0;
            resp_valid      <= '0;
            resp_value      <= '0;
            op_read         <= 1'b0;
            op_idx          <= '0;
        end else begin
            resp_valid <= '0;
            if (grant) begin
                rr_ptr          <= (win == LAST) ? '0 : win + IDX_W'(1);
                rf_chip_enable  <= 1'b1;
                rf_write_enable <= req_write[win];
                rf_address      <= req_address[win*ADDR_WIDTH +: ADDR_WIDTH];
                rf_valueIn      <= req_value[win*DATA_WIDTH +: DATA_WIDTH];
                op_read         <= ~req_write[win];
                op_idx          <= win;
            end else if (state == ACCESS) begin
                rf_chip_enable  <= 1'b0;
                rf_write_enable <= 1'b0;
                if (op_read) begin
                    resp_value         <= rf_valueOut;
                    resp_valid[op_idx] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench: expected grants/responses queued at issue time, popped by a monitor.
module tb_regfile_access_arbiter;
    localparam int N = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_valid, req_write, req_ready, resp_valid;
    logic [N*4-1:0]  req_address;
    logic [N*16-1:0] req_value;
    logic [15:0]   resp_value, rf_valueIn, rf_valueOut;
    logic          rf_chip_enable, rf_write_enable, busy;
    logic [3:0]    rf_address;

    logic        v_valid [N];
    logic        v_write [N];
    logic [3:0]  v_addr  [N];
    logic [15:0] v_val   [N];
    logic [15:0] mem [16];

    int tests_run = 0;
    int tests_failed = 0;
    int exp_grant[$];
    int exp_rid[$];
    logic [15:0] exp_rval[$];

    regfile_access_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .NUM_REQ(N),
                             .WRITE_PRIORITY(1), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_address(req_address), .req_value(req_value), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_value(resp_value), .rf_chip_enable(rf_chip_enable),
        .rf_write_enable(rf_write_enable), .rf_address(rf_address), .rf_valueIn(rf_valueIn),
        .rf_valueOut(rf_valueOut), .busy(busy)
    );

    always #5 clock = ~clock;

    always_comb begin
        req_valid = '0; req_write = '0; req_address = '0; req_value = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = v_valid[i];
            req_write[i]          = v_write[i];
            req_address[i*4 +: 4] = v_addr[i];
            req_value[i*16 +: 16] = v_val[i];
        end
    end

    // Register file model: reg i powers up as 16'h1111*i.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'(16'h1111 * i);
        end else if (rf_chip_enable && rf_write_enable)
            mem[rf_address] <= rf_valueIn;
    end
    assign rf_valueOut = mem[rf_address];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (req_ready != '0) begin
                if (exp_grant.size() == 0) chk("grant_unexpected", 32'(req_ready), 0);
                else chk("grant_order", 32'(req_ready), 32'(1 << exp_grant.pop_front()));
            end
            if (resp_valid != '0) begin
                if (exp_rid.size() == 0) chk("resp_unexpected", 32'(resp_valid), 0);
                else begin
                    chk("resp_valid", 32'(resp_valid), 32'(1 << exp_rid.pop_front()));
                    chk("resp_value", 32'(resp_value), 32'(exp_rval.pop_front()));
                end
            end
        end
    end

    task automatic issue(input int i, input logic w, input logic [3:0] a,
                         input logic [15:0] v, input int budget);
        bit got = 0;
        v_valid[i] = 1'b1; v_write[i] = w; v_addr[i] = a; v_val[i] = v;
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if (req_ready[i]) begin got = 1; break; end
        end
        if (!got) begin
            tests_run++; tests_failed++;
            $display("FAIL grant_timeout: requester %0d got no grant, required one within %0d cycles", i, budget);
        end
        @(posedge clock); #1;
        v_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) v_valid[i] = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic drain(input string nm);
        repeat (6) @(posedge clock);
        #1;
        chk({nm, "_grants_left"}, 32'(exp_grant.size()), 0);
        chk({nm, "_resps_left"}, 32'(exp_rid.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            v_valid[i] = 0; v_write[i] = 0; v_addr[i] = '0; v_val[i] = '0;
        end
        // Reset state, including a request presented during reset.
        v_valid[0] = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_value", 32'(resp_value), 0);
        chk("rst_ce", 32'(rf_chip_enable), 0);
        chk("rst_we", 32'(rf_write_enable), 0);
        chk("rst_addr", 32'(rf_address), 0);
        chk("rst_vin", 32'(rf_valueIn), 0);
        chk("rst_busy", 32'(busy), 0);
        v_valid[0] = 1'b0;
        #1 reset = 1'b0;

        // T1: write then read same register, with latency checks.
        exp_grant = '{2, 0}; exp_rid = '{0}; exp_rval = '{16'h1234};
        issue(2, 1'b1, 4'd3, 16'h1234, 10);
        issue(0, 1'b0, 4'd3, 16'h0, 10);
        chk("t1_ce_n1", 32'(rf_chip_enable), 1);
        chk("t1_we_n1", 32'(rf_write_enable), 0);
        chk("t1_addr_n1", 32'(rf_address), 3);
        chk("t1_busy_n1", 32'(busy), 1);
        @(posedge clock); #1;
        chk("t1_resp_valid_n2", 32'(resp_valid), 32'h1);
        chk("t1_resp_value_n2", 32'(resp_value), 32'h1234);
        chk("t1_ce_n2", 32'(rf_chip_enable), 0);
        drain("t1");

        // T2: three continuous readers, round-robin 0,1,2,0,1,2.
        do_reset();
        exp_grant = '{0, 1, 2, 0, 1, 2};
        exp_rid   = '{0, 1, 2, 0, 1, 2};
        exp_rval  = '{16'h1111, 16'h2222, 16'h4444, 16'h1111, 16'h2222, 16'h4444};
        fork
            begin issue(0, 1'b0, 4'd1, 16'h0, 20); issue(0, 1'b0, 4'd1, 16'h0, 20); end
            begin issue(1, 1'b0, 4'd2, 16'h0, 20); issue(1, 1'b0, 4'd2, 16'h0, 20); end
            begin issue(2, 1'b0, 4'd4, 16'h0, 20); issue(2, 1'b0, 4'd4, 16'h0, 20); end
        join
        drain("t2");

        // T3: simultaneous read and write to reg5; write wins.
        do_reset();
        exp_grant = '{1, 0}; exp_rid = '{0}; exp_rval = '{16'hBEEF};
        fork
            issue(0, 1'b0, 4'd5, 16'h0, 20);
            issue(1, 1'b1, 4'd5, 16'hBEEF, 20);
        join
        drain("t3");

        // T4: back-to-back writes; starved read forced after 4 write grants.
        do_reset();
        exp_grant = '{1, 1, 1, 1, 0, 1}; exp_rid = '{0}; exp_rval = '{16'h7777};
        fork
            issue(0, 1'b0, 4'd7, 16'h0, 40);
            for (int k = 0; k < 5; k++) issue(1, 1'b1, 4'd8, 16'(16'hA000 + k), 20);
        join
        drain("t4");
        chk("t4_mem8", 32'(mem[8]), 32'hA004);

        // T5: reset during the ACCESS cycle of a req1 read.
        do_reset();
        exp_grant = '{1}; exp_rid.delete(); exp_rval.delete();
        issue(1, 1'b0, 4'd2, 16'h0, 10);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("t5_resp_valid", 32'(resp_valid), 0);
        chk("t5_ce", 32'(rf_chip_enable), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_addr", 32'(rf_address), 0);
        chk("t5_grant_q", 32'(exp_grant.size()), 0);
        exp_grant = '{0, 1}; exp_rid = '{0, 1}; exp_rval = '{16'h6666, 16'h2222};
        fork
            issue(0, 1'b0, 4'd6, 16'h0, 20);
            issue(1, 1'b0, 4'd2, 16'h0, 20);
        join
        drain("t5");

        // T6: a one-cycle request during ACCESS is never granted.
        do_reset();
        exp_grant = '{0}; exp_rid = '{0}; exp_rval = '{16'h1111};
        issue(0, 1'b0, 4'd1, 16'h0, 10);
        v_valid[2] = 1'b1; v_write[2] = 1'b1; v_addr[2] = 4'd9; v_val[2] = 16'hABCD;
        @(posedge clock); #1;
        v_valid[2] = 1'b0;
        drain("t6");
        chk("t6_mem9", 32'(mem[9]), 32'h9999);
        chk("t6_ce_idle", 32'(rf_chip_enable), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
